// File: rtl/result_write_scheduler.sv
// result_write_scheduler
// Round-robin arbiter that moves fixed-length result records from several
// match engines into a ring of result slots in the shared result SRAM.
// It owns the slot write pointer and counts slots the host has not yet read,
// so a record is never written over unread data.
module result_write_scheduler #(
    parameter int          NUM_REQ    = 3,
    parameter int          WORDS      = 4,
    parameter logic [31:0] SLOT_BYTES = 32'h0000_060E,
    parameter int          NUM_SLOTS  = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             src_valid,
    input  logic [NUM_REQ*32-1:0]          src_data,
    input  logic                           slot_release,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic                           mem_we,
    output logic [31:0]                    mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic [31:0]                    slot_base,
    output logic [$clog2(NUM_SLOTS+1)-1:0] used_count,
    output logic                           full,
    output logic                           empty
);
    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam int WI = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1'b1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1'b1);
    localparam logic [CW-1:0] SLOTS_CNT = CW'(NUM_SLOTS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [WI-1:0] LAST_REQ  = WI'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_r;
    logic [WI-1:0]       winner_r;
    logic [WI-1:0]       last_winner_r;
    logic [BW-1:0]       beat_r;
    logic [SW-1:0]       slot_idx_r;
    logic [31:0]         slot_base_r;
    logic [CW-1:0]       used_r;
    logic [NUM_REQ-1:0]  gnt_r;
    logic [NUM_REQ-1:0]  done_r;

    logic [WI-1:0]       pick_s;
    logic                beat_valid_s;
    logic                commit_s;
    logic                release_s;
    logic [CW-1:0]       used_next_s;

    // First requester at or after last+1 (mod NUM_REQ); scanning the
    // offsets from far to near leaves the nearest requester selected.
    function automatic logic [WI-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [WI-1:0]      last);
        logic [WI-1:0] sel;
        int            idx;
        sel = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            sel = r[idx] ? WI'(idx) : sel;
        end
        return sel;
    endfunction

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [WI-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Arbitration winner, record commit and net unread-slot count
    always_comb begin
        pick_s       = rr_pick(req, last_winner_r);
        beat_valid_s = (state_r == WRITE) && src_valid[winner_r];
        commit_s     = beat_valid_s && (beat_r == LAST_BEAT);
        release_s    = slot_release && (used_r != '0);
        if (commit_s && !release_s) begin
            used_next_s = used_r + CNT_ONE;
        end else if (!commit_s && release_s) begin
            used_next_s = used_r - CNT_ONE;
        end else begin
            used_next_s = used_r;
        end
    end

    // Write port follows the granted engine only while a burst is in flight
    always_comb begin
        if (state_r == WRITE) begin
            mem_we    = src_valid[winner_r];
            mem_addr  = slot_base_r + {{(30-BW){1'b0}}, beat_r, 2'b00};
            mem_wdata = src_data[{winner_r, 5'b00000} +: 32];
        end else begin
            mem_we    = 1'b0;
            mem_addr  = 32'h0000_0000;
            mem_wdata = 32'h0000_0000;
        end
    end

    // Arbitration FSM, slot pointer and unread-slot bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            winner_r      <= '0;
            last_winner_r <= LAST_REQ;
            beat_r        <= '0;
            slot_idx_r    <= '0;
            slot_base_r   <= BASE_ADDR;
            used_r        <= '0;
            gnt_r         <= '0;
            done_r        <= '0;
        end else begin
            done_r <= '0;
            used_r <= used_next_s;
            case (state_r)
                IDLE: begin
                    if ((req != '0) && !full) begin
                        winner_r <= pick_s;
                        gnt_r    <= one_hot(pick_s);
                        beat_r   <= '0;
                        state_r  <= WRITE;
                    end else begin
                        gnt_r   <= '0;
                        state_r <= IDLE;
                    end
                end
                WRITE: begin
                    if (commit_s) begin
                        gnt_r         <= '0;
                        done_r        <= one_hot(winner_r);
                        last_winner_r <= winner_r;
                        state_r       <= DONE;
                        if (slot_idx_r == LAST_SLOT) begin
                            slot_idx_r  <= '0;
                            slot_base_r <= BASE_ADDR;
                        end else begin
                            slot_idx_r  <= slot_idx_r + SLOT_ONE;
                            slot_base_r <= slot_base_r + SLOT_BYTES;
                        end
                    end else if (beat_valid_s) begin
                        beat_r <= beat_r + BEAT_ONE;
                    end else begin
                        beat_r <= beat_r;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    gnt_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign gnt        = gnt_r;
    assign done       = done_r;
    assign slot_base  = slot_base_r;
    assign used_count = used_r;
    assign full       = (used_r == SLOTS_CNT);
    assign empty      = (used_r == '0);

endmodule

// File: tb/tb_result_write_scheduler.sv
// Testbench for result_write_scheduler: directed scenarios plus randomized
// traffic, checked against a record-level reference model via scoreboards.
module tb_result_write_scheduler;
    localparam int          NR = 3;
    localparam int          W  = 4;
    localparam int          NS = 4;
    localparam logic [31:0] SB = 32'h0000_060E;
    localparam logic [31:0] BA = 32'h0000_0000;
    localparam int          CW = $clog2(NS + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     src_valid;
    logic [NR*32-1:0]  src_data;
    logic              slot_release;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       slot_base;
    logic [CW-1:0]     used_count;
    logic              full;
    logic              empty;

    always #5 clk = ~clk;

    result_write_scheduler #(
        .NUM_REQ(NR), .WORDS(W), .SLOT_BYTES(SB), .NUM_SLOTS(NS), .BASE_ADDR(BA)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .src_valid(src_valid),
        .src_data(src_data), .slot_release(slot_release), .gnt(gnt),
        .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .slot_base(slot_base),
        .used_count(used_count), .full(full), .empty(empty)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NR-1:0] gnt;
        logic [NR-1:0] done;
        logic          we;
        logic [31:0]   base;
        logic [CW-1:0] used;
        logic          full;
        logic          empty;
    } cyc_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    cyc_t cyc_q[$];
    wr_t  wr_q[$];

    // Reference model: which engine owns the port, how many beats it has
    // delivered, which slot it is filling and how many slots are unread.
    bit            m_valid     = 1'b0;
    int            m_owner     = -1;
    int            m_beats     = 0;
    int            m_last      = NR - 1;
    int            m_slot      = 0;
    int            m_used      = 0;
    int            m_done_from = -1;
    logic [NR-1:0] m_last_done = '0;

    function automatic logic [31:0] base_of(input int s);
        return BA + 32'(s) * SB;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] o;
        o = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    function automatic logic [NR*32-1:0] lane(input int i, input logic [31:0] v);
        logic [NR*32-1:0] d;
        d = '0;
        d[i*32 +: 32] = v;
        return d;
    endfunction

    function automatic logic [NR*32-1:0] rnd_data();
        logic [NR*32-1:0] d;
        for (int i = 0; i < NR; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, record what the model expects to see
    // during that cycle, then advance the model across the clock edge.
    task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] v,
                        input logic [NR*32-1:0] d, input logic rel, input logic rs);
        cyc_t e;
        wr_t  w;
        int   commit;
        int   dec;
        int   idx;
        @(posedge clk);
        #1;
        req = r; src_valid = v; src_data = d; slot_release = rel; rst = rs;
        m_last_done = '0;
        if (m_valid) begin
            e.gnt   = (m_owner >= 0) ? onehot(m_owner) : '0;
            e.done  = (m_done_from >= 0) ? onehot(m_done_from) : '0;
            e.we    = (m_owner >= 0) && v[m_owner];
            e.base  = base_of(m_slot);
            e.used  = CW'(m_used);
            e.full  = (m_used == NS);
            e.empty = (m_used == 0);
            cyc_q.push_back(e);
            m_last_done = e.done;
            if (e.we) begin
                w.addr = base_of(m_slot) + 32'(4 * m_beats);
                w.data = d[m_owner*32 +: 32];
                wr_q.push_back(w);
            end
        end
        if (rs) begin
            m_valid = 1'b1; m_owner = -1; m_beats = 0; m_last = NR - 1;
            m_slot = 0; m_used = 0; m_done_from = -1;
        end else if (m_valid) begin
            commit = 0;
            dec = (rel && m_used > 0) ? 1 : 0;
            if (m_done_from >= 0) begin
                m_done_from = -1;
            end else if (m_owner >= 0) begin
                if (v[m_owner]) begin
                    m_beats++;
                    if (m_beats == W) begin
                        commit = 1;
                        m_done_from = m_owner;
                        m_last = m_owner;
                        m_owner = -1;
                        m_slot = (m_slot + 1) % NS;
                    end
                end
            end else if (r != '0 && m_used < NS) begin
                for (int k = 1; k <= NR; k++) begin
                    idx = (m_last + k) % NR;
                    if (r[idx]) begin
                        m_owner = idx;
                        break;
                    end
                end
                m_beats = 0;
            end
            m_used = m_used + commit - dec;
        end
    endtask

    // Monitor: per-cycle status scoreboard plus write-beat scoreboard
    initial begin
        cyc_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("gnt", gnt, e.gnt);
                chk("done", done, e.done);
                chk("mem_we", mem_we, e.we);
                chk("slot_base", slot_base, e.base);
                chk("used_count", used_count, e.used);
                chk("full", full, e.full);
                chk("empty", empty, e.empty);
            end
            if (mem_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none at %0t",
                             mem_addr, mem_wdata, $time);
                end else begin
                    w = wr_q.pop_front();
                    chk("mem_addr", mem_addr, w.addr);
                    chk("mem_wdata", mem_wdata, w.data);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        logic [NR-1:0] want;
        logic [NR-1:0] v;
        req = '0; src_valid = '0; src_data = '0; slot_release = 1'b0; rst = 1'b1;
        want = '0;

        // Reset held two cycles, then every output at its reset value
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_gnt", gnt, 64'd0);
        chk("rst_done", done, 64'd0);
        chk("rst_mem_we", mem_we, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_slot_base", slot_base, 64'd0);
        chk("rst_used", used_count, 64'd0);
        chk("rst_full", full, 64'd0);
        chk("rst_empty", empty, 64'd1);

        // Single request from engine 1, data 0xA0..0xA3
        for (int c = 0; c <= 6; c++) begin
            step((c <= 5) ? 3'b010 : 3'b000, (c >= 1 && c <= 4) ? 3'b010 : 3'b000,
                 lane(1, 32'h0000_00A0 + 32'(c - 1)), 1'b0, 1'b0);
            @(negedge clk);
            if (c == 1) begin
                chk("single_gnt", gnt, 64'h2);
                chk("single_addr0", mem_addr, 64'h0);
                chk("single_data0", mem_wdata, 64'hA0);
            end
            if (c == 4) begin
                chk("single_addr3", mem_addr, 64'hC);
                chk("single_data3", mem_wdata, 64'hA3);
            end
            if (c == 5) begin
                chk("single_done", done, 64'h2);
                chk("single_base", slot_base, 64'h060E);
                chk("single_used", used_count, 64'd1);
            end
        end

        // Round-robin with all requesting, fill to full, release, wrap
        step('0, '0, '0, 1'b0, 1'b1);
        for (int c = 0; c <= 33; c++) begin
            step(3'b111, 3'b111, rnd_data(), (c == 27) || (c == 32), 1'b0);
            @(negedge clk);
            if (c == 1)  begin chk("rr_gnt0", gnt, 64'h1); chk("rr_addr0", mem_addr, 64'h0000); end
            if (c == 7)  begin chk("rr_gnt1", gnt, 64'h2); chk("rr_addr1", mem_addr, 64'h060E); end
            if (c == 13) begin chk("rr_gnt2", gnt, 64'h4); chk("rr_addr2", mem_addr, 64'h0C1C); end
            if (c == 19) begin chk("rr_gnt3", gnt, 64'h1); chk("rr_addr3", mem_addr, 64'h122A); end
            if (c == 23) begin chk("full_set", full, 64'd1); chk("full_used", used_count, 64'd4); end
            if (c == 25) chk("full_no_grant", gnt, 64'h0);
            if (c == 28) begin chk("rel_used", used_count, 64'd3); chk("rel_full", full, 64'd0); end
            if (c == 29) begin chk("wrap_gnt", gnt, 64'h2); chk("wrap_addr", mem_addr, 64'h0); end
            if (c == 33) begin chk("coincide_used", used_count, 64'd3); chk("coincide_done", done, 64'h2); end
        end

        // Stall on engine 0, with a release while empty
        step('0, '0, '0, 1'b0, 1'b1);
        for (int c = 0; c <= 8; c++) begin
            v = (c == 1 || c == 2 || c == 5 || c == 6) ? 3'b001 : 3'b000;
            step((c <= 7) ? 3'b001 : 3'b000, v, rnd_data(), (c == 0), 1'b0);
            @(negedge clk);
            if (c == 1) chk("empty_release", used_count, 64'd0);
            if (c == 3) chk("stall_we_a", mem_we, 64'd0);
            if (c == 4) chk("stall_we_b", mem_we, 64'd0);
            if (c == 5) begin chk("stall_we_c", mem_we, 64'd1); chk("stall_addr", mem_addr, 64'h8); end
            if (c == 6) chk("stall_no_done", done, 64'h0);
            if (c == 7) chk("stall_done", done, 64'h1);
        end

        // Reset in the middle of a burst
        for (int c = 0; c <= 3; c++) begin
            step((c <= 2) ? 3'b100 : 3'b000, (c >= 1) ? 3'b100 : 3'b000,
                 rnd_data(), 1'b0, (c == 2));
            @(negedge clk);
            if (c == 3) begin
                chk("midrst_gnt", gnt, 64'h0);
                chk("midrst_we", mem_we, 64'd0);
                chk("midrst_addr", mem_addr, 64'h0);
                chk("midrst_wdata", mem_wdata, 64'h0);
                chk("midrst_base", slot_base, 64'h0);
                chk("midrst_used", used_count, 64'd0);
                chk("midrst_empty", empty, 64'd1);
            end
        end

        // Randomized traffic: engines request, hold until done, then drop
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!want[i] && $urandom_range(0, 3) == 0) want[i] = 1'b1;
                v[i] = ($urandom_range(0, 3) != 0);
            end
            step(want, v, rnd_data(), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 599) == 0));
            want = want & ~m_last_done;
        end

        step('0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("status_queue_drained", 64'(cyc_q.size()), 64'd0);
        chk("write_queue_drained", 64'(wr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
